// File: rtl/sel_dec_pkg.sv
// -----------------------------------------------------------------------------
// sel_dec_pkg
//
// Shared definitions for the registered selection decoder:
//   - sel_dec_state_t : FSM state encoding (also driven out on the debug port,
//                       so the numeric values are fixed on purpose)
//   - SEL_*           : default parameter values for sel_decoder_q
//   - sel_cnt_w()     : width of the stability counter for a given STABLE_CYC
// -----------------------------------------------------------------------------
package sel_dec_pkg;

    localparam int SEL_IN_W       = 4;
    localparam int SEL_NUM_OUT    = 9;
    localparam int SEL_STABLE_CYC = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        HOLD     = 2'd2,
        WAIT_REL = 2'd3
    } sel_dec_state_t;

    // The counter has to be able to hold the value STABLE_CYC itself.
    function automatic int sel_cnt_w(input int stable_cyc);
        return $clog2(stable_cyc + 1);
    endfunction

endpackage

// File: rtl/sel_onehot.sv
// -----------------------------------------------------------------------------
// sel_onehot
//
// Purely combinational binary-to-one-hot decoder with an in-range flag.
//
// Ports:
//   code_i     [IN_W-1:0]     binary selection code
//   onehot_o   [NUM_OUT-1:0]  one-hot decode, all-zero for codes >= NUM_OUT
//   in_range_o                1 when code_i < NUM_OUT
// -----------------------------------------------------------------------------
module sel_onehot #(
    parameter int IN_W    = 4,
    parameter int NUM_OUT = 9
) (
    input  logic [IN_W-1:0]    code_i,
    output logic [NUM_OUT-1:0] onehot_o,
    output logic               in_range_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot_o[i] = (code_i == IN_W'(i));
        end
    end

    // A code is legal exactly when it lights one of the outputs; deriving the
    // flag this way avoids a mixed-width magnitude compare.
    assign in_range_o = |onehot_o;

endmodule

// File: rtl/sel_decoder_q.sv
// -----------------------------------------------------------------------------
// sel_decoder_q
//
// Registered selection decoder for the vending machine. A raw keypad/coin code
// must be present and unchanged for STABLE_CYC consecutive samples before it is
// decoded. A legal code is presented as a one-hot word over a valid/ready
// handshake; an out-of-range code produces a one-cycle err_range pulse instead.
// Each press yields at most one selection: code_vld must drop before the next
// press is qualified.
//
// Handshake: onehot_out/out_vld are registered. Once out_vld is high the word
// is held unchanged until the consumer samples out_vld & out_rdy on a rising
// edge; out_rdy while out_vld is low has no effect. A clear in the handshake
// cycle wins, so the consumer must discard a selection seen together with clear.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   code_in      raw binary selection code
//   code_vld     code_in is driven (key/coin present)
//   clear        synchronous abort back to IDLE
//   onehot_out   registered one-hot selection, zero when not presenting
//   out_vld      onehot_out valid
//   out_rdy      consumer accepts
//   err_range    one-cycle pulse, qualified code >= NUM_OUT
//   busy         FSM is not in IDLE
//   dbg_state_o  current FSM state (sel_dec_state_t encoding)
// -----------------------------------------------------------------------------
module sel_decoder_q
    import sel_dec_pkg::*;
#(
    parameter int IN_W       = SEL_IN_W,
    parameter int NUM_OUT    = SEL_NUM_OUT,
    parameter int STABLE_CYC = SEL_STABLE_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    code_in,
    input  logic               code_vld,
    input  logic               clear,
    output logic [NUM_OUT-1:0] onehot_out,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic               err_range,
    output logic               busy,
    output logic [1:0]         dbg_state_o
);

    localparam int             CW      = sel_cnt_w(STABLE_CYC);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYC);
    // With STABLE_CYC=1 the first sample already qualifies.
    localparam logic           SINGLE  = (STABLE_CYC == 1);

    sel_dec_state_t     state_q, state_d;
    logic [IN_W-1:0]    code_q, code_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_OUT-1:0] onehot_q, onehot_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;

    logic               qual_done;
    logic [NUM_OUT-1:0] dec_onehot;
    logic               dec_in_range;

    // Qualification only completes on a cycle where code_vld=1 and code_in is
    // the code being counted (either just captured or equal to code_q), so the
    // decoder can look at code_in directly. This keeps the decode off the
    // code_q/code_d path and out of the next-state loop.
    sel_onehot #(
        .IN_W    (IN_W),
        .NUM_OUT (NUM_OUT)
    ) u_onehot (
        .code_i     (code_in),
        .onehot_o   (dec_onehot),
        .in_range_o (dec_in_range)
    );

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            code_q   <= '0;
            cnt_q    <= '0;
            onehot_q <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        onehot_d  = onehot_q;
        vld_d     = vld_q;
        err_d     = 1'b0;       // err_range is a single-cycle pulse
        qual_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (code_vld) begin
                    code_d    = code_in;
                    cnt_d     = CNT_ONE;
                    state_d   = QUAL;
                    qual_done = SINGLE;
                end
            end

            QUAL: begin
                if (!code_vld) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (code_in != code_q) begin
                    // Bounce: restart counting on the new code.
                    code_d    = code_in;
                    cnt_d     = CNT_ONE;
                    qual_done = SINGLE;
                end else begin
                    // Saturating increment; never wraps.
                    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    qual_done = (cnt_d == CNT_MAX);
                end
            end

            HOLD: begin
                // vld_q is always 1 here, so out_rdy alone completes the transfer.
                if (out_rdy) begin
                    onehot_d = '0;
                    vld_d    = 1'b0;
                    state_d  = WAIT_REL;
                end
            end

            WAIT_REL: begin
                if (!code_vld) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Qualification complete: present the selection or flag the code.
        if (qual_done) begin
            cnt_d = '0;
            if (dec_in_range) begin
                onehot_d = dec_onehot;
                vld_d    = 1'b1;
                state_d  = HOLD;
            end else begin
                onehot_d = '0;
                err_d    = 1'b1;
                state_d  = WAIT_REL;
            end
        end

        // Abort overrides everything decided above, including a handshake.
        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            onehot_d = '0;
            vld_d    = 1'b0;
            err_d    = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign onehot_out  = onehot_q;
    assign out_vld     = vld_q;
    assign err_range   = err_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sel_decoder_q.sv
module tb_sel_decoder_q;

    localparam int IN_W = 4;
    localparam int NO   = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_QUAL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_WREL = 2'd3;

    // ---------------------------------------------------------------- signals
    logic            clk;
    logic            rst_n;
    logic [IN_W-1:0] code_in;
    logic            code_vld;
    logic            clear;
    logic            out_rdy;

    logic [NO-1:0]   onehot_out;
    logic            out_vld;
    logic            err_range;
    logic            busy;
    logic [1:0]      dbg_state;

    logic [NO-1:0]   onehot1;
    logic            vld1;
    logic            err1;
    logic            busy1;
    logic [1:0]      state1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NO-1:0] exp_q[$];
    int            exp_err = 0;

    // ------------------------------------------------------------------- DUTs
    sel_decoder_q #(.IN_W(IN_W), .NUM_OUT(NO), .STABLE_CYC(3)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_in     (code_in),
        .code_vld    (code_vld),
        .clear       (clear),
        .onehot_out  (onehot_out),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .err_range   (err_range),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    sel_decoder_q #(.IN_W(IN_W), .NUM_OUT(NO), .STABLE_CYC(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_in     (code_in),
        .code_vld    (code_vld),
        .clear       (clear),
        .onehot_out  (onehot1),
        .out_vld     (vld1),
        .out_rdy     (out_rdy),
        .err_range   (err1),
        .busy        (busy1),
        .dbg_state_o (state1)
    );

    // ------------------------------------------------------- clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ check task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // --------------------------------------------------------- driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [IN_W-1:0] c);
        code_in  = c;
        code_vld = 1'b1;
    endtask

    task automatic release_key();
        code_vld = 1'b0;
    endtask

    // ------------------------------------------------------------ scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot_invariant",
                  32'(out_vld ? $onehot(onehot_out) : (onehot_out == '0)), 32'd1);
            if (out_vld && out_rdy && !clear) begin
                check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("sb_onehot", 32'(onehot_out), 32'(exp_q.pop_front()));
                end
            end
            if (err_range) begin
                check("err_pending", 32'(exp_err > 0), 32'd1);
                if (exp_err > 0) exp_err--;
                check("err_onehot", 32'(onehot_out), 32'd0);
                check("err_vld", 32'(out_vld), 32'd0);
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        rst_n    = 1'b0;
        code_in  = 4'd5;
        code_vld = 1'b1;
        clear    = 1'b0;
        out_rdy  = 1'b0;

        // 1. Reset holds everything low even with a key pressed.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_onehot", 32'(onehot_out), 32'd0);
            check("rst_vld", 32'(out_vld), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        release_key();
        tick(1);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // 2. Held key with consumer ready: one selection, after 3 edges.
        out_rdy = 1'b1;
        exp_q.push_back(9'h020);
        press(4'd5);
        tick(1);
        check("s2_lat1", 32'(out_vld), 32'd0);
        tick(1);
        check("s2_lat2", 32'(out_vld), 32'd0);
        tick(1);
        check("s2_vld", 32'(out_vld), 32'd1);
        check("s2_onehot", 32'(onehot_out), 32'h020);
        check("s2_state_hold", 32'(dbg_state), 32'(S_HOLD));
        tick(1);
        check("s2_vld_drop", 32'(out_vld), 32'd0);
        check("s2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("s2_no_repeat", 32'(out_vld), 32'd0);
        end
        release_key();
        tick(1);
        check("s2_idle", 32'(busy), 32'd0);
        exp_q.push_back(9'h020);
        press(4'd5);
        tick(2);
        check("s2b_lat", 32'(out_vld), 32'd0);
        tick(1);
        check("s2b_vld", 32'(out_vld), 32'd1);
        check("s2b_onehot", 32'(onehot_out), 32'h020);
        release_key();
        tick(2);

        // 3. Back-pressure: word held 5 cycles while code_in wanders.
        out_rdy = 1'b0;
        exp_q.push_back(9'h100);
        press(4'd8);
        tick(3);
        code_in = 4'd2;
        for (int i = 0; i < 4; i++) begin
            check("s3_hold_vld", 32'(out_vld), 32'd1);
            check("s3_hold_onehot", 32'(onehot_out), 32'h100);
            tick(1);
        end
        out_rdy = 1'b1;
        check("s3_hs_vld", 32'(out_vld), 32'd1);
        check("s3_hs_onehot", 32'(onehot_out), 32'h100);
        tick(1);
        check("s3_cleared_vld", 32'(out_vld), 32'd0);
        check("s3_cleared_onehot", 32'(onehot_out), 32'd0);
        check("s3_wait_rel", 32'(dbg_state), 32'(S_WREL));
        release_key();
        tick(1);
        check("s3_idle", 32'(dbg_state), 32'(S_IDLE));

        // 4. Bounce 3,3,7,7,7 -> only 7 decodes.
        exp_q.push_back(9'h080);
        press(4'd3); tick(1); check("s4_e1", 32'(out_vld), 32'd0);
        press(4'd3); tick(1); check("s4_e2", 32'(out_vld), 32'd0);
        press(4'd7); tick(1); check("s4_e3", 32'(out_vld), 32'd0);
        press(4'd7); tick(1); check("s4_e4", 32'(out_vld), 32'd0);
        press(4'd7); tick(1);
        check("s4_vld", 32'(out_vld), 32'd1);
        check("s4_onehot", 32'(onehot_out), 32'h080);
        release_key();
        tick(2);
        // 3,3,(gap),3,3 -> never qualifies.
        press(4'd3); tick(1); check("s4b_e1", 32'(out_vld), 32'd0);
        press(4'd3); tick(1); check("s4b_e2", 32'(out_vld), 32'd0);
        release_key(); tick(1); check("s4b_gap", 32'(dbg_state), 32'(S_IDLE));
        press(4'd3); tick(1); check("s4b_e4", 32'(out_vld), 32'd0);
        press(4'd3); tick(1); check("s4b_e5", 32'(out_vld), 32'd0);
        release_key();
        tick(2);

        // 5. Out-of-range code.
        exp_err++;
        press(4'd12);
        tick(3);
        check("s5_err", 32'(err_range), 32'd1);
        check("s5_vld", 32'(out_vld), 32'd0);
        check("s5_state", 32'(dbg_state), 32'(S_WREL));
        tick(1);
        check("s5_err_pulse", 32'(err_range), 32'd0);
        check("s5_state2", 32'(dbg_state), 32'(S_WREL));
        tick(1);
        check("s5_state3", 32'(dbg_state), 32'(S_WREL));
        release_key();
        tick(1);
        check("s5_idle", 32'(dbg_state), 32'(S_IDLE));

        // 6a. clear during QUAL.
        press(4'd6);
        tick(2);
        check("s6a_qual", 32'(dbg_state), 32'(S_QUAL));
        clear = 1'b1;
        tick(1);
        check("s6a_idle", 32'(dbg_state), 32'(S_IDLE));
        check("s6a_vld", 32'(out_vld), 32'd0);
        clear = 1'b0;
        release_key();
        tick(3);
        check("s6a_quiet", 32'(out_vld), 32'd0);

        // 6b. clear coincident with the handshake cancels it.
        out_rdy = 1'b1;
        press(4'd1);
        tick(3);
        check("s6b_vld", 32'(out_vld), 32'd1);
        check("s6b_onehot", 32'(onehot_out), 32'h002);
        clear = 1'b1;
        tick(1);
        check("s6b_vld_drop", 32'(out_vld), 32'd0);
        check("s6b_idle", 32'(dbg_state), 32'(S_IDLE));
        clear = 1'b0;
        release_key();
        tick(2);

        // Async reset mid-HOLD drops outputs without a clock edge.
        out_rdy = 1'b0;
        press(4'd4);
        tick(3);
        check("ar_hold_vld", 32'(out_vld), 32'd1);
        check("ar_hold_onehot", 32'(onehot_out), 32'h010);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_vld", 32'(out_vld), 32'd0);
        check("ar_onehot", 32'(onehot_out), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        release_key();
        out_rdy = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // 6c. STABLE_CYC=1 instance: valid one cycle after the first sample.
        exp_q.push_back(9'h020);
        press(4'd5);
        tick(1);
        check("s6c_vld1", 32'(vld1), 32'd1);
        check("s6c_onehot1", 32'(onehot1), 32'h020);
        check("s6c_main_not_yet", 32'(out_vld), 32'd0);
        tick(1);
        check("s6c_vld1_drop", 32'(vld1), 32'd0);
        check("s6c_state1", 32'(state1), 32'(S_WREL));
        tick(1);
        check("s6c_main_vld", 32'(out_vld), 32'd1);
        release_key();
        tick(2);
        check("s6c_idle1", 32'(busy1), 32'd0);

        // Final scoreboard drain.
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("err_empty", 32'(exp_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sel_decoder_q.md
Name: sel_decoder_q

Overview:
- Parametrised, registered successor to the vending machine's combinational binary-to-one-hot selection decoder.
- Qualifies a raw keypad/coin selection code by requiring it to be stable for STABLE_CYC consecutive cycles.
- Presents the decoded one-hot selection to the vend controller over a valid/ready handshake and flags out-of-range codes.
- Issues one selection per press: the input must be released before another is accepted.

Parameters:
- IN_W, 4, width of the binary selection code.
- NUM_OUT, 9, number of one-hot outputs. Codes 0..NUM_OUT-1 are legal. Constraint: NUM_OUT <= 2**IN_W.
- STABLE_CYC, 3, consecutive identical valid samples required before decode. Constraint: STABLE_CYC >= 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- code_in  in  IN_W  raw selection code
- code_vld  in  1  code_in is driven (key/coin present)
- clear  in  1  synchronous abort, highest priority after rst_n
- onehot_out  out  NUM_OUT  registered one-hot selection; all-zero when not presenting
- out_vld  out  1  onehot_out valid
- out_rdy  in  1  consumer accepts
- err_range  out  1  one-cycle pulse: qualified code >= NUM_OUT
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: one clock and asynchronous active-low reset, rst_n (clk rising edge). While rst_n=0: state=IDLE, onehot_out=0, out_vld=0, err_range=0, busy=0, internal code register=0, counter=0. Asynchronous assertion; outputs change immediately. Deassertion is synchronised externally.
- States: IDLE, QUAL, HOLD, WAIT_REL.
- IDLE:
  - If code_vld=1, capture code_in and set cnt=1.
  - If STABLE_CYC=1, go directly to decode (see QUAL exit); otherwise go to QUAL.
- QUAL: each cycle, evaluate in this priority order:
  - code_vld=0: go to IDLE, cnt=0.
  - code_vld=1 and code_in differs from captured code: recapture, cnt=1, stay in QUAL (bounce restart).
  - code_vld=1 and code_in equal: cnt++.
  - When cnt reaches STABLE_CYC:
    - If code < NUM_OUT: load onehot_out = 1<<code, set out_vld=1, go to HOLD.
    - Otherwise: pulse err_range for exactly 1 cycle, keep onehot_out=0, go to WAIT_REL.
- Latency: with code_vld held and code constant from the first sampling edge E0, out_vld rises after edge E0+STABLE_CYC-1, i.e. it is visible STABLE_CYC cycles after code first presented.
- HOLD:
  - onehot_out and out_vld are held stable, independent of code_in/code_vld, until out_rdy=1.
  - On the handshake cycle (out_vld&out_rdy), the next edge clears onehot_out and out_vld and moves to WAIT_REL.
  - out_rdy when out_vld=0 is ignored.
- WAIT_REL: stay until code_vld=0, then go to IDLE. A held key never produces a second selection.
- clear=1 (synchronous), any state: next edge goes to IDLE, onehot_out=0, out_vld=0, cnt=0, and err_range is suppressed. clear wins over a simultaneous handshake or qualification; the consumer must treat a same-cycle clear as cancelling the selection.
- Counter width: $clog2(STABLE_CYC+1) bits. The counter saturates and never wraps.
- Invariant: onehot_out is all-zero or has exactly one bit set; it is nonzero iff out_vld=1.
- busy=1 in QUAL, HOLD and WAIT_REL.

Decomposition:
- Shared package sel_dec_pkg holds:
  - typedef enum logic [1:0] sel_dec_state_t {IDLE, QUAL, HOLD, WAIT_REL}.
  - Default parameter constants: SEL_IN_W=4, SEL_NUM_OUT=9, SEL_STABLE_CYC=3.
- One natural sub-module: sel_onehot, a purely combinational parametrised binary-to-one-hot decoder with in-range flag (IN_W, NUM_OUT). It replaces the hand-written fixed decoder and is instantiated once, feeding the output register.

Test Plan (defaults IN_W=4, NUM_OUT=9, STABLE_CYC=3):
1. rst_n=0 with code_vld=1, code_in=5 → onehot_out=9'h000, out_vld=0, busy=0 throughout. rst_n pulled low mid-HOLD → outputs drop to 0 without waiting for a clk edge.
2. code_in=5, code_vld=1 held 10 cycles, out_rdy=1 → onehot_out=9'h020 with out_vld high exactly 1 cycle, after the 3rd sampling edge. No second assertion until code_vld drops, then a new 3-cycle press produces 9'h020 again.
3. code_in=8 held, out_rdy=0 for 4 cycles then 1 → onehot_out=9'h100 with out_vld stable for 5 cycles even if code_in changes to 2 meanwhile. Cleared the edge after the handshake.
4. Bounce sequence code_in=3,3,7,7,7 (code_vld=1) → no output for 3; onehot_out=9'h080 after the 5th edge. Sequence 3,3,(code_vld=0),3,3 → no output.
5. code_in=12 held 3 cycles → err_range=1 for exactly one cycle, onehot_out=0, out_vld never high, state WAIT_REL until release.
6. clear=1 during QUAL at cnt=2 → IDLE next edge, no output. clear asserted in the same cycle as out_vld&out_rdy → out_vld=0 next edge, IDLE. Repeat scenario 2 with STABLE_CYC=1 → out_vld visible 1 cycle after first sample.
